// File: rtl/regfile_scoreboard_if.sv
// Operand-read, writeback and issue signals between decode/writeback and the
// register file with its pending-write scoreboard.
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  we;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  busy_any;

    modport master (
        output rs1_addr, rs2_addr, we, rd_addr, rd_data, issue_valid, issue_rd,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_any
    );

    modport slave (
        input  rs1_addr, rs2_addr, we, rd_addr, rd_data, issue_valid, issue_rd,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_any
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write integer register file (x0 hardwired to zero) with optional
// same-cycle writeback bypass and a per-register pending-write scoreboard.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_scoreboard_if.slave   bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam bit BYP_EN   = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_r;
    logic [NUM_REGS-1:0]   busy_next_s;
    logic                  busy_any_r;
    logic                  wr_en_s;
    logic                  hit1_s;
    logic                  hit2_s;
    logic [DATA_WIDTH-1:0] rs1_data_s;
    logic [DATA_WIDTH-1:0] rs2_data_s;
    logic                  rs1_busy_s;
    logic                  rs2_busy_s;

    assign wr_en_s = bus.we && (bus.rd_addr != {ADDR_WIDTH{1'b0}});
    assign hit1_s  = BYP_EN && bus.we && (bus.rd_addr == bus.rs1_addr);
    assign hit2_s  = BYP_EN && bus.we && (bus.rd_addr == bus.rs2_addr);

    // Register storage: reset clears everything; writes to x0 are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[bus.rd_addr] <= bus.rd_data;
        end
    end

    // Scoreboard next state: a new issue beats a completing write to the same register.
    always_comb begin
        busy_next_s = {NUM_REGS{1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            if (bus.issue_valid && (bus.issue_rd == ADDR_WIDTH'(i))) begin
                busy_next_s[i] = 1'b1;
            end else if (wr_en_s && (bus.rd_addr == ADDR_WIDTH'(i))) begin
                busy_next_s[i] = 1'b0;
            end else begin
                busy_next_s[i] = busy_r[i];
            end
        end
    end

    // Scoreboard state and its drain indicator, both taken from the same next value.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= {NUM_REGS{1'b0}};
            busy_any_r <= 1'b0;
        end else begin
            busy_r     <= busy_next_s;
            busy_any_r <= |busy_next_s;
        end
    end

    // Read port 1: x0 reads zero even when a bypass would otherwise match.
    always_comb begin
        rs1_data_s = {DATA_WIDTH{1'b0}};
        rs1_busy_s = 1'b0;
        if (bus.rs1_addr == {ADDR_WIDTH{1'b0}}) begin
            rs1_data_s = {DATA_WIDTH{1'b0}};
            rs1_busy_s = 1'b0;
        end else if (hit1_s) begin
            rs1_data_s = bus.rd_data;
            rs1_busy_s = 1'b0;
        end else begin
            rs1_data_s = regs_r[bus.rs1_addr];
            rs1_busy_s = busy_r[bus.rs1_addr];
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rs2_data_s = {DATA_WIDTH{1'b0}};
        rs2_busy_s = 1'b0;
        if (bus.rs2_addr == {ADDR_WIDTH{1'b0}}) begin
            rs2_data_s = {DATA_WIDTH{1'b0}};
            rs2_busy_s = 1'b0;
        end else if (hit2_s) begin
            rs2_data_s = bus.rd_data;
            rs2_busy_s = 1'b0;
        end else begin
            rs2_data_s = regs_r[bus.rs2_addr];
            rs2_busy_s = busy_r[bus.rs2_addr];
        end
    end

    assign bus.rs1_data = rs1_data_s;
    assign bus.rs2_data = rs2_data_s;
    assign bus.rs1_busy = rs1_busy_s;
    assign bus.rs2_busy = rs2_busy_s;
    assign bus.busy_any = busy_any_r;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed checks of regfile_scoreboard (bypass and no-bypass
// builds side by side) against an array-based reference model.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, issue_rd;
    logic [31:0] rd_data;
    logic        we, issue_valid;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_byp ();
    regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_nb ();

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .bus(bus_byp));
    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .bus(bus_nb));

    assign bus_byp.rs1_addr = rs1_addr;    assign bus_nb.rs1_addr = rs1_addr;
    assign bus_byp.rs2_addr = rs2_addr;    assign bus_nb.rs2_addr = rs2_addr;
    assign bus_byp.we = we;                assign bus_nb.we = we;
    assign bus_byp.rd_addr = rd_addr;      assign bus_nb.rd_addr = rd_addr;
    assign bus_byp.rd_data = rd_data;      assign bus_nb.rd_data = rd_data;
    assign bus_byp.issue_valid = issue_valid; assign bus_nb.issue_valid = issue_valid;
    assign bus_byp.issue_rd = issue_rd;    assign bus_nb.issue_rd = issue_rd;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && we && rd_addr == a) return rd_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (byp && we && rd_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check_outputs();
        check_val("byp_rs1_data", bus_byp.rs1_data, exp_data(rs1_addr, 1'b1));
        check_val("byp_rs2_data", bus_byp.rs2_data, exp_data(rs2_addr, 1'b1));
        check_val("byp_rs1_busy", {31'd0, bus_byp.rs1_busy}, {31'd0, exp_busy(rs1_addr, 1'b1)});
        check_val("byp_rs2_busy", {31'd0, bus_byp.rs2_busy}, {31'd0, exp_busy(rs2_addr, 1'b1)});
        check_val("byp_busy_any", {31'd0, bus_byp.busy_any}, {31'd0, |m_busy});
        check_val("nb_rs1_data", bus_nb.rs1_data, exp_data(rs1_addr, 1'b0));
        check_val("nb_rs2_data", bus_nb.rs2_data, exp_data(rs2_addr, 1'b0));
        check_val("nb_rs1_busy", {31'd0, bus_nb.rs1_busy}, {31'd0, exp_busy(rs1_addr, 1'b0)});
        check_val("nb_rs2_busy", {31'd0, bus_nb.rs2_busy}, {31'd0, exp_busy(rs2_addr, 1'b0)});
        check_val("nb_busy_any", {31'd0, bus_nb.busy_any}, {31'd0, |m_busy});
    endtask

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_busy = 32'd0;
        end else begin
            if (we && rd_addr != 5'd0) begin
                m_regs[rd_addr] = rd_data;
                m_busy[rd_addr] = 1'b0;
            end
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        end
    endtask

    // Inputs are stable from the preceding negedge; check, clock, update model.
    task automatic cycle(input bit do_check);
        #1;
        if (do_check) check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                         input logic w, input logic [4:0] rd, input logic [31:0] d,
                         input logic iv, input logic [4:0] ird);
        rst = r; rs1_addr = a1; rs2_addr = a2; we = w; rd_addr = rd; rd_data = d;
        issue_valid = iv; issue_rd = ird;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_busy = 32'd0;
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        @(negedge clk);
        cycle(1'b0);

        // Fill with random contents and pending writes, then reset.
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, rand_addr(), rand_addr(), 1'($urandom_range(0, 1)), rand_addr(),
                  $urandom, 1'($urandom_range(0, 1)), rand_addr());
            cycle(1'b1);
        end
        drive(1'b1, 5'd5, 5'd31, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        cycle(1'b1);
        drive(1'b0, 5'd5, 5'd31, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #1;
        check_val("rst_rs1_data", bus_byp.rs1_data, 32'd0);
        check_val("rst_rs2_data", bus_byp.rs2_data, 32'd0);
        check_val("rst_busy_any", {31'd0, bus_byp.busy_any}, 32'd0);
        cycle(1'b1);

        // Same-cycle bypass of a write to x7.
        drive(1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0);
        #1;
        check_val("bypass_same_cycle", bus_byp.rs1_data, 32'hDEADBEEF);
        check_val("nobypass_same_cycle", bus_nb.rs1_data, 32'd0);
        cycle(1'b1);
        drive(1'b0, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #1;
        check_val("stored_after_write", bus_nb.rs1_data, 32'hDEADBEEF);
        cycle(1'b1);

        // x0 ignores writes, bypass and issue.
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0);
        #1;
        check_val("x0_bypass", bus_byp.rs1_data, 32'd0);
        cycle(1'b1);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #1;
        check_val("x0_busy_any", {31'd0, bus_byp.busy_any}, 32'd0);
        cycle(1'b1);

        // Issue to x3, then complete it.
        drive(1'b0, 5'd0, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        cycle(1'b1);
        drive(1'b0, 5'd0, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #1;
        check_val("x3_busy", {31'd0, bus_byp.rs2_busy}, 32'd1);
        cycle(1'b1);
        drive(1'b0, 5'd0, 5'd3, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0);
        #1;
        check_val("x3_wb_byp_busy", {31'd0, bus_byp.rs2_busy}, 32'd0);
        check_val("x3_wb_nb_busy", {31'd0, bus_nb.rs2_busy}, 32'd1);
        cycle(1'b1);
        drive(1'b0, 5'd0, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        cycle(1'b1);

        // x9: set wins over clear; then set x4 while clearing x9.
        drive(1'b0, 5'd9, 5'd4, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        cycle(1'b1);
        drive(1'b0, 5'd9, 5'd4, 1'b1, 5'd9, 32'hA, 1'b1, 5'd9);
        cycle(1'b1);
        drive(1'b0, 5'd9, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #1;
        check_val("x9_set_wins", {31'd0, bus_byp.rs1_busy}, 32'd1);
        check_val("x9_data", bus_byp.rs1_data, 32'hA);
        cycle(1'b1);
        drive(1'b0, 5'd9, 5'd4, 1'b1, 5'd9, 32'hB, 1'b1, 5'd4);
        cycle(1'b1);
        drive(1'b0, 5'd9, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #1;
        check_val("x4_set", {31'd0, bus_byp.rs2_busy}, 32'd1);
        check_val("x9_cleared", {31'd0, bus_byp.rs1_busy}, 32'd0);
        cycle(1'b1);

        // Reset beats a concurrent write and drops pending entries.
        drive(1'b0, 5'd6, 5'd2, 1'b1, 5'd6, 32'hFF, 1'b1, 5'd2);
        cycle(1'b1);
        drive(1'b0, 5'd6, 5'd2, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
        cycle(1'b1);
        drive(1'b1, 5'd6, 5'd2, 1'b1, 5'd6, 32'h77, 1'b0, 5'd0);
        cycle(1'b1);
        drive(1'b0, 5'd6, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #1;
        check_val("rst_wins_data", bus_nb.rs1_data, 32'd0);
        check_val("rst_wins_busy_any", {31'd0, bus_nb.busy_any}, 32'd0);
        cycle(1'b1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 99) == 0), rand_addr(), rand_addr(),
                  1'($urandom_range(0, 1)), rand_addr(), $urandom,
                  1'($urandom_range(0, 2) != 0), rand_addr());
            cycle(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
